muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit plus its controlling FSM, beside the single-cycle ALU in execute.
//  Accepts one op from execute, iterates one bit per cycle, and holds the pipeline via `stall` until the result is ready.
//  Returns result and destination register for the execute->memory register.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
//  CNT_W  6  iteration counter width (>= clog2(XLEN)+1)
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     asynchronous, active-low reset
//  start    in   1     execute presents a valid M-extension op this cycle
//  funct3   in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a     in   XLEN  rs1 value
//  op_b     in   XLEN  rs2 value
//  rd_in    in   5     destination register
//  kill     in   1     flush: abort current op
//  stall    out  1     hold upstream stages
//  busy     out  1     FSM not IDLE
//  done     out  1     one-cycle pulse; result/rd_out valid
//  result   out  XLEN  final value
//  rd_out   out  5     destination register of completed op
// BEHAVIOUR
//  Reset (rst=0, any state): state=IDLE; busy,done,stall=0; result=0; rd_out=0; counter, accumulators cleared.
//  States: IDLE, RUN, FIX, DONE (encodings in package).
//  IDLE: start=1 & kill=0 -> latch funct3, rd_in, |op_a|,|op_b| (signedness per funct3),
//   result sign; counter=XLEN; -> RUN. start ignored in any other state.
//  stall = (IDLE & start & !kill) | RUN | FIX. Deasserts in DONE so the next instr advances that edge.
//  RUN, mul: shift-add, 2*XLEN product register, one multiplier bit/cycle.
//  RUN, div: restoring division, one quotient bit/cycle; remainder XLEN+1 bits.
//  counter decrements each RUN cycle; RUN -> FIX when counter reaches 1 (XLEN RUN cycles).
//  FIX: apply sign (two's complement negate if needed), select low/high half or quotient/remainder -> DONE.
//  DONE: done=1, result/rd_out valid for this cycle only, then -> IDLE; result/rd_out hold until next DONE.
//  Latency: start edge to done pulse = XLEN+2 cycles (34 for XLEN=32).
//  Signed rules: MULH both signed; MULHSU op_a signed, op_b unsigned; DIV/REM both signed.
//   Quotient sign = sign_a^sign_b; remainder sign = sign_a.
//  Divide by zero (op_b=0): fast path IDLE->FIX, skip RUN. Quotient = all ones; remainder = op_a.
//  Signed overflow (DIV/REM, op_a=0x80000000, op_b=-1): fast path. Quotient=0x80000000, rem=0.
//  Fast-path latency = 2 cycles. stall semantics unchanged.
//  kill: in any state, next state IDLE, no done pulse, stall deasserts next cycle.
//   kill with start in IDLE: op not accepted.
//  kill and FSM reaching DONE in the same cycle: done still pulses (op already retired).
//  Reset mid-operation: immediate abort to reset values; no done.
// STRUCTURE
//  Package muldiv_pkg: funct3 constants (FUNCT3_MUL..FUNCT3_REMU), state typedef/localparams, XLEN default.
//  One sub-module: muldiv_datapath (shift registers, adder/subtractor, sign fix), driven by
//   load/step/fix strobes from the FSM in this module. No other hierarchy.
// TESTING
//  MUL 7*6: start, funct3=000 -> done on cycle 34 after start, result=42, rd_out=rd_in.
//  MULH 0xFFFFFFFF*0xFFFFFFFF (-1*-1) -> 0. MULHU same operands -> 0xFFFFFFFE. MULHSU -1,2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
//  DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000: done 2 cycles after start.
//  stall high from start through FIX, low in DONE; second start while busy ignored, its op never completes.
//  kill at RUN cycle 10 -> IDLE next cycle, no done. rst low at RUN cycle 5 -> all outputs 0 immediately.
//  After release, a new MUL 3*3 gives 9.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared constants, state encoding and signedness helpers
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// muldiv_datapath : shift-add multiplier / restoring divider with sign fix-up
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            fast,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ones = '1;

  logic [2:0]      r_f3;
  logic            r_neg;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;

  logic            w_neg_a, w_neg_b, w_is_div, w_div0, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic [XLEN-1:0] w_addend;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rs;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_quot_s, w_rem_s, w_final;

  assign w_neg_a  = op_a_signed(funct3) & op_a[XLEN-1];
  assign w_neg_b  = op_b_signed(funct3) & op_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? -op_a : op_a;
  assign w_mag_b  = w_neg_b ? -op_b : op_b;
  assign w_is_div = funct3[2];
  assign w_div0   = w_is_div & (op_b == '0);
  assign w_ovf    = w_is_div & ~funct3[0] & (op_a == c_min) & (op_b == c_ones);
  assign fast     = w_div0 | w_ovf;

  // Multiply: {r_acc, r_lo} is the 2*XLEN product register, shifted right each step.
  assign w_addend = r_lo[0] ? r_opnd : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

  // Divide: partial remainder stays below the divisor, so the low XLEN bits of the difference suffice.
  assign w_rs   = {r_acc, r_lo[XLEN-1]};
  assign w_ge   = (w_rs >= {1'b0, r_opnd});
  assign w_diff = w_rs[XLEN-1:0] - r_opnd;

  assign w_prod   = {r_acc, r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quot_s = r_neg ? -r_lo : r_lo;
  assign w_rem_s  = r_neg ? -r_acc : r_acc;

  always_comb begin
    w_final = w_prod_s[2*XLEN-1:XLEN];
    if (r_f3[2])
      w_final = r_f3[1] ? w_rem_s : w_quot_s;
    else if (r_f3 == FUNCT3_MUL)
      w_final = w_prod_s[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (load) begin
        r_f3 <= funct3;
        if (fast) begin
          // Fast-path results are preloaded so the fix stage only selects them.
          r_neg  <= 1'b0;
          r_opnd <= '0;
          r_lo   <= w_div0 ? c_ones : c_min;
          r_acc  <= w_div0 ? op_a : '0;
        end else if (w_is_div) begin
          r_neg  <= funct3[1] ? w_neg_a : (w_neg_a ^ w_neg_b);
          r_opnd <= w_mag_b;
          r_lo   <= w_mag_a;
          r_acc  <= '0;
        end else begin
          r_neg  <= w_neg_a ^ w_neg_b;
          r_opnd <= w_mag_a;
          r_lo   <= w_mag_b;
          r_acc  <= '0;
        end
      end else if (step) begin
        if (r_f3[2]) begin
          r_acc <= w_ge ? w_diff : w_rs[XLEN-1:0];
          r_lo  <= {r_lo[XLEN-2:0], w_ge};
        end else begin
          r_acc <= w_sum[XLEN:1];
          r_lo  <= {w_sum[0], r_lo[XLEN-1:1]};
        end
      end
      if (fix)
        r_result <= w_final;
    end
  end

  assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// muldiv_sequencer : RV32M iterative multiply/divide unit with pipeline stall
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_rd_pend;
  logic [4:0]       r_rd_out;
  logic             w_load, w_step, w_fix, w_fast;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    stall  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !kill && rst) begin
          w_load = 1'b1;
          stall  = 1'b1;
          w_next = w_fast ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        stall  = 1'b1;
        w_step = !kill;
        if (kill)
          w_next = ST_IDLE;
        else if (r_cnt == c_cnt_one)
          w_next = ST_FIX;
      end
      ST_FIX: begin
        stall = 1'b1;
        if (kill) begin
          w_next = ST_IDLE;
        end else begin
          w_fix  = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rd_pend <= '0;
      r_rd_out  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cnt     <= c_cnt_init;
        r_rd_pend <= rd_in;
      end else if (w_step) begin
        r_cnt <= r_cnt - c_cnt_one;
      end
      if (w_fix)
        r_rd_out <= r_rd_pend;
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .step   (w_step),
    .fix    (w_fix),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .fast   (w_fast),
    .result (result)
  );

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign rd_out = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// tb_muldiv_sequencer : directed vectors for the RV32M multiply/divide unit
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec  = 0;
  int n_miss = 0;

  muldiv_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .kill   (kill),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic watch_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  // Issues one op and measures cycles from the start edge to the done pulse.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int cyc;
    int stall_low;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    stall_low = 0;
    while (!done && cyc < 60) begin
      if (!stall) stall_low++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
    check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    check({tag, "_stall_run"}, 32'(stall_low), 32'd0);
  endtask

  initial begin
    int cyc;
    int pulses;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    rst = 1'b1;

    run_op("mul",    3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       34);
    run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000, 34);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34);
    run_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       34);
    run_op("remu",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        34);
    run_op("divu0",  3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 2);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        2);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 2);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        2);

    // A second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd6; rd_in = 5'd5;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cyc == 3) begin
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
      end
      start = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("busy_lat", 32'(cyc), 32'd34);
    check("busy_res", result, 32'd42);
    check("busy_rd", {27'd0, rd_out}, 32'd5);
    watch_done(40, pulses);
    check("busy_no_second", 32'(pulses), 32'd0);

    // Kill in the middle of RUN.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd11;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 10; cyc++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_stall", {31'd0, stall}, 32'd0);
    watch_done(40, pulses);
    check("kill_no_done", 32'(pulses), 32'd0);
    check("kill_res_hold", result, 32'd42);

    // Kill together with start in IDLE: op is not accepted.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
    #1 check("killstart_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("killstart_busy", {31'd0, busy}, 32'd0);

    // Reset asserted in the middle of RUN.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd6; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 5; cyc++) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_done(40, pulses);
    check("rst_no_done", 32'(pulses), 32'd0);

    run_op("mul_after_rst", 3'b000, 32'd3, 32'd3, 5'd7, 32'd9, 34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
